// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared state encodings and default timing constants for the
//               pushbutton conditioning stage.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t c_IDLE      = 2'd0;
    localparam btn_state_t c_ARMING    = 2'd1;
    localparam btn_state_t c_HELD      = 2'd2;
    localparam btn_state_t c_RELEASING = 2'd3;

    localparam int c_DB_CYCLES_DEF     = 16;
    localparam int c_REPEAT_DELAY_DEF  = 64;
    localparam int c_REPEAT_PERIOD_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Reset-to-zero flop chain bringing an asynchronous level into
//               the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_pulse_gen
// Description : Synchronizes and debounces a raw pushbutton and emits one
//               registered pulse per accepted press. Auto-repeat while held
//               is built when BTN_AUTO_REPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = c_DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = c_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = c_REPEAT_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       w_pulse,
    output logic       btn_level,
    output logic [1:0] state
);

    localparam int               c_CNT_W   = $clog2(DB_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    btn_state_t           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_pulse;
    logic                 r_level;
    logic                 w_sync;
    logic                 w_press;
    logic                 w_rpt_fire;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (btn_in),
        .o_q (w_sync)
    );

    assign w_press = (r_state == c_ARMING) && w_sync && (r_cnt == c_DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= w_press | w_rpt_fire;
            case (r_state)
                c_IDLE: begin
                    if (w_sync) begin
                        r_state <= c_ARMING;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                c_ARMING: begin
                    if (!w_sync) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state <= c_HELD;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_HELD: begin
                    if (!w_sync) begin
                        r_state <= c_RELEASING;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                default: begin
                    // Any high sample during release is bounce: back to HELD silently.
                    if (w_sync) begin
                        r_state <= c_HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX) + 1;
    localparam logic [c_RPT_W-1:0] c_RPT_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);

    logic [c_RPT_W-1:0] r_rpt;
    logic               r_rpt_first;

    assign w_rpt_fire = (r_state == c_HELD) && w_sync &&
                        (r_rpt == (r_rpt_first ? c_RPT_DELAY_LAST : c_RPT_PERIOD_LAST));

    // Counter only advances while staying in HELD; any other cycle rearms the initial delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end else if ((r_state == c_HELD) && w_sync) begin
            if (w_rpt_fire) begin
                r_rpt       <= '0;
                r_rpt_first <= 1'b0;
            end else begin
                r_rpt <= r_rpt + c_RPT_W'(1);
            end
        end else begin
            r_rpt       <= '0;
            r_rpt_first <= 1'b1;
        end
    end
`else
    logic [31:0] w_rpt_params_unused;

    assign w_rpt_params_unused = 32'(REPEAT_DELAY ^ REPEAT_PERIOD);
    assign w_rpt_fire          = 1'b0;
`endif

    assign w_pulse   = r_pulse;
    assign btn_level = r_level;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_pulse_gen
// Description : Randomized scoreboard bench for btn_pulse_gen against a
//               run-length debounce model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

    localparam int SYNC_STAGES   = 2;
    localparam int DB_CYCLES     = 4;
    localparam int REPEAT_DELAY  = 8;
    localparam int REPEAT_PERIOD = 4;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       w_pulse;
    logic       btn_level;
    logic [1:0] state;

    btn_pulse_gen #(
        .SYNC_STAGES   (SYNC_STAGES),
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .w_pulse   (w_pulse),
        .btn_level (btn_level),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       pulse;
        logic       level;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_npul = 0;
    int   got_npul = 0;

    // Reference model: the accepted level flips once DB_CYCLES consecutive
    // synchronized samples disagree with it; the repeat timer counts cycles
    // held high since the level (re)settled high.
    bit   m_pipe[$];
    bit   m_level;
    int   m_run;
    int   m_t;

    always @(posedge clk) begin
        exp_t e;
        bit   s;
        logic p;
        cyc = cyc + 1;
        p   = 1'b0;
        if (rst) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
            m_level = 1'b0;
            m_run   = 0;
            m_t     = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(btn_in);
            if (!m_level) begin
                if (s) begin
                    m_run = m_run + 1;
                    if (m_run == DB_CYCLES) begin
                        m_level = 1'b1;
                        m_run   = 0;
                        m_t     = 0;
                        p       = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (s) begin
                    if (m_run > 0) begin
                        m_run = 0;
                        m_t   = 0;
                    end else begin
                        m_t = m_t + 1;
`ifdef BTN_AUTO_REPEAT_EN
                        if (m_t >= REPEAT_DELAY && ((m_t - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
                            p = 1'b1;
`endif
                    end
                end else begin
                    m_run = m_run + 1;
                    if (m_run == DB_CYCLES) begin
                        m_level = 1'b0;
                        m_run   = 0;
                    end
                end
            end
        end
        e.cyc   = cyc;
        e.pulse = p;
        e.level = m_level;
        e.st    = !m_level ? ((m_run > 0) ? 2'd1 : 2'd0) : ((m_run > 0) ? 2'd3 : 2'd2);
        if (p) exp_npul = exp_npul + 1;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (w_pulse === 1'b1) got_npul = got_npul + 1;
            n_tests = n_tests + 3;
            if (w_pulse !== e.pulse) begin
                n_fail = n_fail + 1;
                $display("FAIL w_pulse cyc=%0d got=%b exp=%b", e.cyc, w_pulse, e.pulse);
            end
            if (btn_level !== e.level) begin
                n_fail = n_fail + 1;
                $display("FAIL btn_level cyc=%0d got=%b exp=%b", e.cyc, btn_level, e.level);
            end
            if (state !== e.st) begin
                n_fail = n_fail + 1;
                $display("FAIL state cyc=%0d got=%0d exp=%0d", e.cyc, state, e.st);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int n;
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clean press and release
        hold(1'b1, 20);
        hold(1'b0, 20);
        // Press glitch
        hold(1'b1, 2);
        hold(1'b0, 10);
        // Release bounce
        hold(1'b1, 15);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 15);
        // Reset while arming, button still held through it
        hold(1'b1, 4);
        pulse_reset();
        hold(1'b1, 20);
        hold(1'b0, 15);
        // Long hold exercising the repeat engine when built
        hold(1'b1, 45);
        hold(1'b0, 3);
        hold(1'b1, 20);
        hold(1'b0, 15);
        // Five clean presses
        for (int k = 0; k < 5; k++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end

        for (int k = 0; k < 300; k++) begin
            v = $urandom_range(0, 1);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
            hold(v[0], n);
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        hold(1'b0, 20);

        @(negedge clk);
        #1;
        n_tests = n_tests + 1;
        if (got_npul != exp_npul) begin
            n_fail = n_fail + 1;
            $display("FAIL pulse_count got=%0d exp=%0d", got_npul, exp_npul);
        end
        n_tests = n_tests + 1;
        if (exp_q.size() > 1) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain got=%0d exp<=1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
